// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor (D = A - B), LSB first, one bit per clock.
// Optional SERSUB_ADD_EN adds an op input (1 = subtract, 0 = add).
`timescale 1ns/1ps

module serial_subtractor #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
`ifdef SERSUB_ADD_EN
    input  logic             op,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] D,
    output logic             Bout,
    output logic             V,
    output logic             Z
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             cb_q, cb_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
`ifdef SERSUB_ADD_EN
    logic             op_q, op_d;
`endif
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             v_q, v_d;
    logic             z_q, z_d;

    logic             sub_mode;
    logic             bit_a;
    logic             bit_b;
    logic             bit_d;
    logic             cb_next;
    logic [WIDTH-1:0] res_next;
    logic             accept;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (count_q == LAST) state_d = DONE;
            DONE:    state_d = start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Full-subtractor / full-adder cell and datapath next values
    always_comb begin
`ifdef SERSUB_ADD_EN
        sub_mode = op_q;
`else
        sub_mode = 1'b1;
`endif
        bit_a    = a_sh_q[0];
        bit_b    = b_sh_q[0];
        bit_d    = bit_a ^ bit_b ^ cb_q;
        if (sub_mode) begin
            cb_next = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & cb_q);
        end else begin
            cb_next = (bit_a & bit_b) | ((bit_a ^ bit_b) & cb_q);
        end
        res_next = {bit_d, res_q[WIDTH-1:1]};
        accept   = start && ((state_q == IDLE) || (state_q == DONE));

        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;
        cb_d    = cb_q;
        count_d = count_q;
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
`ifdef SERSUB_ADD_EN
        op_d    = op_q;
`endif
        diff_d  = diff_q;
        bout_d  = bout_q;
        v_d     = v_q;
        z_d     = z_q;

        if (accept) begin
            a_sh_d  = A;
            b_sh_d  = B;
            cb_d    = 1'b0;
            count_d = '0;
            a_msb_d = A[WIDTH-1];
            b_msb_d = B[WIDTH-1];
`ifdef SERSUB_ADD_EN
            op_d    = op;
`endif
        end else if (state_q == RUN) begin
            a_sh_d  = {1'b0, a_sh_q[WIDTH-1:1]};
            b_sh_d  = {1'b0, b_sh_q[WIDTH-1:1]};
            res_d   = res_next;
            cb_d    = cb_next;
            count_d = count_q + CNT_W'(1);
            // Visible results change only on the edge that enters DONE
            if (count_q == LAST) begin
                diff_d = res_next;
                bout_d = cb_next;
                if (sub_mode) begin
                    v_d = (a_msb_q ^ b_msb_q) & (a_msb_q ^ res_next[WIDTH-1]);
                end else begin
                    v_d = ~(a_msb_q ^ b_msb_q) & (a_msb_q ^ res_next[WIDTH-1]);
                end
                z_d = ~|res_next;
            end
        end

        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            cb_q    <= 1'b0;
            count_q <= '0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
`ifdef SERSUB_ADD_EN
            op_q    <= 1'b1;
`endif
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            v_q     <= 1'b0;
            z_q     <= 1'b0;
        end else begin
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            cb_q    <= cb_d;
            count_q <= count_d;
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
`ifdef SERSUB_ADD_EN
            op_q    <= op_d;
`endif
            busy_q  <= busy_d;
            done_q  <= done_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            v_q     <= v_d;
            z_q     <= z_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign D    = diff_q;
    assign Bout = bout_q;
    assign V    = v_q;
    assign Z    = z_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor at WIDTH=8; covers add mode when SERSUB_ADD_EN is defined.
`timescale 1ns/1ps

module tb_serial_subtractor;

    localparam int unsigned WIDTH = 8;
    localparam int          LIMIT = 40;

    typedef struct packed {
        logic [WIDTH-1:0] d;
        logic             bout;
        logic             v;
        logic             z;
    } exp_t;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             op;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] D;
    logic             Bout;
    logic             V;
    logic             Z;

    exp_t sb_q[$];
    exp_t last_exp;
    int   n_vec  = 0;
    int   n_miss = 0;
    int   cyc;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
`ifdef SERSUB_ADD_EN
        .op    (op),
`endif
        .busy  (busy),
        .done  (done),
        .D     (D),
        .Bout  (Bout),
        .V     (V),
        .Z     (Z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: wide arithmetic for D/Bout, signed integer range for V
    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic sub);
        exp_t       e;
        logic [WIDTH:0] w;
        int         sa, sb, sr;
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (sub) begin
            w  = {1'b0, a} - {1'b0, b};
            sr = sa - sb;
        end else begin
            w  = {1'b0, a} + {1'b0, b};
            sr = sa + sb;
        end
        e.d    = w[WIDTH-1:0];
        e.bout = w[WIDTH];
        e.v    = (sr > 127) || (sr < -128);
        e.z    = (w[WIDTH-1:0] == '0);
        return e;
    endfunction

    // Scoreboard consumer
    always @(negedge clk) begin
        if (done === 1'b1) begin
            check_eq("done_expected", 32'(sb_q.size() != 0), 32'd1);
            check_eq("busy_at_done", 32'(busy), 32'd0);
            if (sb_q.size() != 0) begin
                last_exp = sb_q.pop_front();
                check_eq("D", 32'(D), 32'(last_exp.d));
                check_eq("Bout", 32'(Bout), 32'(last_exp.bout));
                check_eq("V", 32'(V), 32'(last_exp.v));
                check_eq("Z", 32'(Z), 32'(last_exp.z));
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 of the accepting edge
    task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic sub, input bit push);
        A     = a;
        B     = b;
        op    = sub;
        start = 1'b1;
        if (push) sb_q.push_back(model(a, b, sub));
        @(posedge clk);
        #1;
        start = 1'b0;
        A     = $urandom;
        B     = $urandom;
        check_eq("busy_after_accept", 32'(busy), 32'd1);
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        while (cycles < LIMIT) begin
            @(posedge clk);
            #1;
            cycles++;
            if (done === 1'b1) return;
        end
    endtask

    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic sub);
        int c;
        start_op(a, b, sub, 1'b1);
        wait_done(c);
        check_eq("latency", 32'(c), 32'(WIDTH));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int c;
        rst   = 1'b1;
        start = 1'b0;
        A     = '0;
        B     = '0;
        op    = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_D", 32'(D), 32'd0);
        check_eq("rst_Bout", 32'(Bout), 32'd0);
        check_eq("rst_V", 32'(V), 32'd0);
        check_eq("rst_Z", 32'(Z), 32'd0);

        run_op(8'h05, 8'h03, 1'b1);
        run_op(8'h03, 8'h05, 1'b1);
        run_op(8'h00, 8'h01, 1'b1);
        run_op(8'h80, 8'h01, 1'b1);
        run_op(8'h2A, 8'h2A, 1'b1);

        // Results hold through idle
        repeat (3) @(posedge clk);
        #1;
        check_eq("hold_idle_D", 32'(D), 32'h00);
        check_eq("hold_idle_Z", 32'(Z), 32'd1);

        // start during RUN cycle 3 is ignored, then back-to-back from DONE
        start_op(8'h10, 8'h01, 1'b1, 1'b1);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        A     = 8'h99;
        B     = 8'h11;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(c);
        check_eq("latency_ignored_start", 32'(c), 32'(WIDTH - 3));
        start_op(8'h20, 8'h10, 1'b1, 1'b1);
        check_eq("hold_run_D", 32'(D), 32'h0F);
        wait_done(c);
        check_eq("b2b_done_gap", 32'(c + 1), 32'(WIDTH + 1));
        @(posedge clk);
        #1;

        // Reset at RUN cycle 4 discards the operation
        start_op(8'h55, 8'h22, 1'b1, 1'b0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_eq("midrst_busy", 32'(busy), 32'd0);
        check_eq("midrst_done", 32'(done), 32'd0);
        check_eq("midrst_D", 32'(D), 32'd0);
        check_eq("midrst_Bout", 32'(Bout), 32'd0);
        check_eq("midrst_V", 32'(V), 32'd0);
        check_eq("midrst_Z", 32'(Z), 32'd0);
        repeat (12) begin
            @(posedge clk);
            #1;
        end
        run_op(8'h10, 8'h01, 1'b1);

`ifdef SERSUB_ADD_EN
        run_op(8'hFF, 8'h01, 1'b0);
        run_op(8'h7F, 8'h01, 1'b0);
        run_op(8'h80, 8'h80, 1'b0);
`endif

        for (int i = 0; i < 6; i++) begin
`ifdef SERSUB_ADD_EN
            run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
`else
            run_op(WIDTH'($urandom), WIDTH'($urandom), 1'b1);
`endif
        end

        repeat (2) @(posedge clk);
        check_eq("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial two's-complement subtractor computing D = A - B, one bit per clock, LSB first.
- Uses a single full-subtractor cell with a registered borrow. This is the subtract counterpart of the ripple full-adder datapath.
- Sits beside the ALU in the unpipelined processor as a low-area, multi-cycle subtract/compare unit with a start/done handshake.

Parameters:
- WIDTH, 32, operand and result width in bits (minimum 2).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- start  input  1  request pulse; sampled only when the unit is not busy
- A  input  WIDTH  minuend; captured on the accepting edge
- B  input  WIDTH  subtrahend; captured on the accepting edge
- busy  output  1  high while the operation is in progress
- done  output  1  one-cycle pulse; result outputs are valid
- D  output  WIDTH  difference
- Bout  output  1  final borrow out (1 = unsigned A < B)
- V  output  1  signed overflow
- Z  output  1  D == 0

Behaviour:
- Reset (rst=1 at a rising edge):
  - state=IDLE; busy=0, done=0, D=0, Bout=0, V=0, Z=0.
  - Internal operand shift registers, borrow register and bit counter are cleared.
  - Reset wins over any other input in the same cycle, including mid-operation: the in-flight result is discarded and no done pulse is produced.
- States: IDLE, RUN, DONE.
- IDLE:
  - If start=1, latch A and B, set borrow=0 and count=0, go to RUN.
  - Otherwise stay in IDLE; outputs hold their last values.
- RUN (busy=1), each edge processes bit i=count:
  - a = A_sh[0], b = B_sh[0]
  - d = a ^ b ^ borrow
  - borrow_next = (~a & b) | (~(a ^ b) & borrow)
  - Shift A_sh and B_sh right by 1; shift the result register right, inserting d at the MSB; count++.
  - When count reaches WIDTH-1 (last bit processed on this edge), go to DONE.
- DONE (busy=0, done=1 for exactly one cycle):
  - D = result register; Bout = final borrow.
  - V = (A[MSB] ^ B[MSB]) & (A[MSB] ^ D[MSB]), using the latched A and B.
  - Z = ~|D.
  - Next edge goes to IDLE. If start=1 during DONE, the new request is accepted directly (state->RUN, new operands latched), allowing back-to-back operation.
- Latency:
  - Start accepted at edge t0; done is high in the cycle after edge t0+WIDTH.
  - Throughput is one result per WIDTH+1 cycles back-to-back.
- Output holding:
  - D, Bout, V and Z update only on entry to DONE.
  - They hold their values through IDLE and through a subsequent RUN until the next DONE.
- start while busy=1 (RUN) is ignored and not queued.
- A and B may change freely after the accepting edge.
- Wrap-around: the result is modulo 2^WIDTH, e.g. 0 - 1 = all ones with Bout=1.

Optional Feature:
- Macro SERSUB_ADD_EN.
- Defined:
  - Adds port op (input, 1), latched with the operands: op=1 subtract, op=0 add.
  - Add mode: d = a ^ b ^ c, c_next = (a & b) | ((a ^ b) & c), initial carry 0.
  - Bout reports carry out.
  - V = ~(A[MSB] ^ B[MSB]) & (A[MSB] ^ D[MSB]).
- Undefined: no op port; the unit always subtracts.

Test Plan (WIDTH=8):
- A=0x05, B=0x03, start pulse -> busy for 8 cycles; done pulse 8 edges after acceptance; D=0x02, Bout=0, V=0, Z=0.
- A=0x03, B=0x05 -> D=0xFE, Bout=1, V=0, Z=0. A=0x00, B=0x01 -> D=0xFF, Bout=1.
- Signed overflow cases:
  - A=0x80, B=0x01 -> D=0x7F, V=1, Bout=0.
  - A=0x2A, B=0x2A -> D=0x00, Z=1, V=0, Bout=0.
- Busy and back-to-back handling:
  - Start 0x10-0x01; pulse start with 0x99/0x11 during RUN cycle 3 -> ignored; D=0x0F.
  - Start asserted during the DONE cycle with 0x20-0x10 -> accepted; second done 9 cycles after the first; D=0x10.
- Reset mid-operation:
  - rst=1 at RUN cycle 4 -> next cycle busy=0, done=0, D=0, Bout=0, V=0, Z=0; no done pulse afterwards.
  - A new start then completes normally.
- SERSUB_ADD_EN defined:
  - op=0, A=0xFF, B=0x01 -> D=0x00, Bout(carry)=1, Z=1, V=0.
  - op=0, A=0x7F, B=0x01 -> D=0x80, V=1.
